// File: rtl/mimosa_pkg.sv
// Shared constants, stimulus names and FSM state types for the serial stimulus path.
// Pure declarations: no latency, no flow control.
package mimosa_pkg;

   parameter int NUM_EXT_STIM = 11;

   parameter logic [7:0] CMD_SET   = 8'h53;
   parameter logic [7:0] CMD_CLEAR = 8'h43;

   typedef logic [NUM_EXT_STIM-1:0] stim_vec_t;

   typedef enum logic [3:0] {
      STIM_TICKLE = 4'd0,
      STIM_FEED   = 4'd1,
      STIM_PET    = 4'd2,
      STIM_PLAY   = 4'd3,
      STIM_LOUD   = 4'd4,
      STIM_DARK   = 4'd5,
      STIM_COLD   = 4'd6,
      STIM_WARM   = 4'd7,
      STIM_SHAKE  = 4'd8,
      STIM_QUIET  = 4'd9,
      STIM_BRIGHT = 4'd10
   } stim_e;

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP,
      R_BREAK
   } rx_state_e;

   typedef enum logic {
      P_CMD,
      P_INDEX
   } parse_state_e;

endpackage

// File: rtl/uart_stimulus_receiver_if.sv
// Serial line in, held stimulus vector and receive/parse status pulses out.
// Status outputs are single-cycle pulses with no backpressure; the host side only drives uart_rx.
interface uart_stimulus_receiver_if;
   import mimosa_pkg::*;

   logic      uart_rx;
   stim_vec_t stimuli_ext;
   logic [7:0] rx_byte;
   logic      byte_valid;
   logic      frame_err;
   logic      cmd_err;

   modport master (
      output uart_rx,
      input  stimuli_ext, rx_byte, byte_valid, frame_err, cmd_err
   );

   modport slave (
      input  uart_rx,
      output stimuli_ext, rx_byte, byte_valid, frame_err, cmd_err
   );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: sync, start/data/stop sampling at mid-bit; byte_valid/frame_err 2 + C/2 + 9C cycles after the line falls.
// No backpressure: every byte is pulsed once and must be consumed that cycle.
module uart_rx_core
   import mimosa_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      byte_q, byte_d;
   logic            bv_q, bv_d;
   logic            fe_q, fe_d;
   logic            s1_q, rxs_q, rxs_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         state_q    <= R_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_q     <= '0;
         bv_q       <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         s1_q       <= uart_rx;
         rxs_q      <= s1_q;
         rxs_prev_q <= rxs_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_q     <= byte_d;
         bv_q       <= bv_d;
         fe_q       <= fe_d;
      end
   end

   // Each sample decision is made one cycle early so the registered pulse lands on the mid-bit cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      bv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (!rxs_q && rxs_prev_q) begin
               state_d = R_START;
               cnt_d   = CW'(1);
               bit_d   = '0;
            end
         end
         R_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rxs_q ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               shift_d = {rxs_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = R_STOP;
            end
         end
         R_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               if (rxs_q) begin
                  byte_d  = shift_q;
                  bv_d    = 1'b1;
                  state_d = R_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = R_BREAK;
               end
            end
         end
         R_BREAK: begin
            cnt_d = '0;
            if (rxs_q) state_d = R_IDLE;
         end
         default: state_d = R_IDLE;
      endcase
   end

   assign rx_byte    = byte_q;
   assign byte_valid = bv_q;
   assign frame_err  = fe_q;

endmodule

// File: rtl/uart_stimulus_receiver.sv
// Parses 'S'<idx> / 'C' commands from the UART into a held stimulus vector; updates one cycle after byte_valid.
// No backpressure; each set holds the whole vector for HOLD_CYCLES cycles via one shared counter.
module uart_stimulus_receiver
   import mimosa_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int HOLD_CYCLES  = 32768
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_stimulus_receiver_if.slave  bus
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

   logic [7:0]   rx_byte;
   logic         byte_valid;
   logic         frame_err;

   parse_state_e pstate_q, pstate_d;
   stim_vec_t    stim_q, stim_d;
   logic [HW-1:0] hold_q, hold_d;
   logic         cerr_q, cerr_d;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rx    (bus.uart_rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pstate_q <= P_CMD;
         stim_q   <= '0;
         hold_q   <= '0;
         cerr_q   <= 1'b0;
      end else begin
         pstate_q <= pstate_d;
         stim_q   <= stim_d;
         hold_q   <= hold_d;
         cerr_q   <= cerr_d;
      end
   end

   // A set in the expiry cycle ORs onto stim_q, not stim_d, so the old bits survive the reload.
   always_comb begin
      pstate_d = pstate_q;
      stim_d   = stim_q;
      cerr_d   = 1'b0;
      hold_d   = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
      if (hold_q == HW'(1)) stim_d = '0;
      if (byte_valid) begin
         case (pstate_q)
            P_CMD: begin
               if (rx_byte == CMD_SET) begin
                  pstate_d = P_INDEX;
               end else if (rx_byte == CMD_CLEAR) begin
                  stim_d = '0;
                  hold_d = '0;
               end
            end
            P_INDEX: begin
               pstate_d = P_CMD;
               if (rx_byte < 8'(NUM_EXT_STIM)) begin
                  stim_d = stim_q | (stim_vec_t'(1) << rx_byte[3:0]);
                  hold_d = HOLD_LOAD;
               end else begin
                  cerr_d = 1'b1;
               end
            end
            default: pstate_d = P_CMD;
         endcase
      end else if (frame_err && pstate_q == P_INDEX) begin
         pstate_d = P_CMD;
      end
   end

   assign bus.stimuli_ext = stim_q;
   assign bus.rx_byte     = rx_byte;
   assign bus.byte_valid  = byte_valid;
   assign bus.frame_err   = frame_err;
   assign bus.cmd_err     = cerr_q;

endmodule
